// File: rtl/motor_drive.sv
// motor_drive: soft-start scaling, steering mix and deadband compensation feeding period-synchronous PWM for two motor bridges
module motor_drive #(
  parameter logic [10:0] MIN_DUTY = 11'd160,
  parameter int STEER_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwr_up,
  input  logic        vld,
  input  logic [11:0] PID_cntrl,
  input  logic [7:0]  ss_tmr,
  input  logic        en_steer,
  input  logic [11:0] steer_pot,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        lft_rev,
  output logic        rght_rev
);
  logic clr, v1, v2, l_dir, r_dir;
  logic signed [19:0] prod;
  logic signed [12:0] off;
  logic [13:0] l_sum, r_sum;
  logic [11:0] ss_spd;
  logic [10:0] cnt, l_sh, r_sh, l_act, r_act;
  function automatic logic [11:0] sat12(input logic [13:0] s);
    return (s[13] && !(&s[12:11])) ? 12'h800 : (!s[13] && |s[12:11]) ? 12'h7FF : s[11:0];
  endfunction
  function automatic logic [10:0] duty_of(input logic [11:0] spd);
    logic [12:0] mag, sum;
    mag = spd[11] ? 13'd0 - {spd[11], spd} : {1'b0, spd};
    sum = mag + {2'b00, MIN_DUTY};
    return (spd == 12'd0) ? 11'd0 : (sum > 13'd2047) ? 11'h7FF : sum[10:0];
  endfunction
  assign clr = rst | ~pwr_up;
  assign prod = $signed(PID_cntrl) * $signed({1'b0, ss_tmr});
  assign off = en_steer ? ($signed({1'b0, steer_pot} - 13'h800) >>> STEER_SHIFT) : 13'sd0;
  assign l_sum = {{2{ss_spd[11]}}, ss_spd} + {off[12], off};
  assign r_sum = {{2{ss_spd[11]}}, ss_spd} - {off[12], off};
  always_ff @(posedge clk) begin
    if (clr) begin
      {v1, v2, ss_spd, lft_spd, rght_spd} <= '0;
      {l_sh, r_sh, l_dir, r_dir, l_act, r_act, lft_rev, rght_rev} <= '0;
      {cnt, lft_pwm, rght_pwm} <= '0;
    end else begin
      cnt <= cnt + 11'd1;
      v1 <= vld;
      v2 <= v1;
      if (vld) ss_spd <= 12'(prod >>> 8);
      if (v1) begin
        lft_spd <= sat12(l_sum);
        rght_spd <= sat12(r_sum);
      end
      if (v2) begin
        l_sh <= duty_of(lft_spd);
        r_sh <= duty_of(rght_spd);
        l_dir <= lft_spd[11];
        r_dir <= rght_spd[11];
      end
      // a direction change idles the bridge for one full period before driving the other way
      if (&cnt) begin
        lft_rev <= l_dir;
        rght_rev <= r_dir;
        l_act <= (l_dir != lft_rev) ? 11'd0 : l_sh;
        r_act <= (r_dir != rght_rev) ? 11'd0 : r_sh;
      end
      lft_pwm <= cnt < l_act;
      rght_pwm <= cnt < r_act;
    end
  end
endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: directed vectors for motor_drive with hand-computed speeds, duties and directions
module tb_motor_drive;
  logic clk = 0, rst = 1, pwr_up = 1, vld = 0, en_steer = 0;
  logic [11:0] PID_cntrl = 0, steer_pot = 12'h800;
  logic [7:0] ss_tmr = 0;
  logic [11:0] lft_spd, rght_spd;
  logic lft_pwm, rght_pwm, lft_rev, rght_rev;
  logic [10:0] tcnt = 0;
  int checks = 0, errors = 0;

  motor_drive dut (
    .clk(clk), .rst(rst), .pwr_up(pwr_up), .vld(vld), .PID_cntrl(PID_cntrl),
    .ss_tmr(ss_tmr), .en_steer(en_steer), .steer_pot(steer_pot),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .lft_pwm(lft_pwm), .rght_pwm(rght_pwm),
    .lft_rev(lft_rev), .rght_rev(rght_rev)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= (rst || !pwr_up) ? 11'd0 : tcnt + 11'd1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [11:0] pid, input logic [7:0] ss, input logic es, input logic [11:0] pot);
    @(negedge clk);
    PID_cntrl = pid; ss_tmr = ss; en_steer = es; steer_pot = pot; vld = 1;
    @(negedge clk);
    vld = 0;
    @(negedge clk);
  endtask

  task automatic chk_spd(input string tag, input int l, input int r);
    chk({tag, "_lspd"}, int'($signed(lft_spd)), l);
    chk({tag, "_rspd"}, int'($signed(rght_spd)), r);
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(tcnt) != v && n < 5000);
    if (n >= 5000) chk("cnt_timeout", n, 0);
  endtask

  task automatic measure(input string tag, input int l_exp, input int r_exp, input int lrev_exp, input int rrev_exp);
    int lh = 0, rh = 0, bad = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      lh += int'(lft_pwm);
      rh += int'(rght_pwm);
      if (int'(lft_rev) != lrev_exp || int'(rght_rev) != rrev_exp) bad++;
    end
    chk({tag, "_lhi"}, lh, l_exp);
    chk({tag, "_rhi"}, rh, r_exp);
    chk({tag, "_rev_bad"}, bad, 0);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk_spd("reset", 0, 0);
    chk("reset_pwm", int'({lft_pwm, rght_pwm}), 0);
    chk("reset_rev", int'({lft_rev, rght_rev}), 0);
    rst = 0;
    send(12'h400, 8'd255, 0, 12'h800);
    chk_spd("fwd", 1020, 1020);
    wait_cnt(0);
    measure("fwd", 1180, 1180, 0, 0);
    send(12'h7FF, 8'd0, 0, 12'h800);
    chk_spd("ss0", 0, 0);
    wait_cnt(0);
    measure("ss0", 0, 0, 0, 0);
    send(12'h7FF, 8'd255, 1, 12'hFFF);
    chk_spd("steer_r", 2047, 1784);
    wait_cnt(0);
    measure("steer_r", 2047, 1944, 0, 0);
    send(12'h800, 8'd255, 1, 12'h000);
    chk_spd("neg_sat", -2048, -1784);
    wait_cnt(0);
    measure("neg_rev0", 0, 0, 1, 1);
    measure("neg_rev1", 2047, 1944, 1, 1);
    send(12'h400, 8'd255, 0, 12'h800);
    wait_cnt(0);
    measure("to_fwd0", 0, 0, 0, 0);
    measure("to_fwd1", 1180, 1180, 0, 0);
    send(12'hC00, 8'd255, 0, 12'h800);
    chk_spd("bwd", -1020, -1020);
    wait_cnt(0);
    measure("to_bwd0", 0, 0, 1, 1);
    measure("to_bwd1", 1180, 1180, 1, 1);
    send(12'h400, 8'd64, 0, 12'h800);
    send(12'hC00, 8'd255, 0, 12'h800);
    chk_spd("last_win", -1020, -1020);
    wait_cnt(0);
    measure("last_win", 1180, 1180, 1, 1);
    wait_cnt(600);
    pwr_up = 0;
    @(negedge clk);
    chk_spd("pwr_off", 0, 0);
    chk("pwr_off_pwm", int'({lft_pwm, rght_pwm}), 0);
    chk("pwr_off_rev", int'({lft_rev, rght_rev}), 0);
    send(12'h400, 8'd255, 0, 12'h800);
    repeat (3) @(negedge clk);
    chk_spd("pwr_off_vld", 0, 0);
    chk("pwr_off_vld_pwm", int'({lft_pwm, rght_pwm}), 0);
    pwr_up = 1;
    wait_cnt(0);
    measure("pwr_back", 0, 0, 0, 0);
    send(12'h400, 8'd255, 0, 12'h800);
    wait_cnt(0);
    measure("pre_rst", 1180, 1180, 0, 0);
    wait_cnt(600);
    rst = 1;
    @(negedge clk);
    chk_spd("rst_mid", 0, 0);
    chk("rst_mid_pwm", int'({lft_pwm, rght_pwm}), 0);
    rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
